// File: rtl/rv_hazard_ctrl_pkg.sv
// rv_pp_pkg: shared forwarding codes, scoreboard entry type and match helper.
// Contents:
//   FWD_*      EX operand-select codes (00 regfile, 10 EX/MEM, 01 MEM/WB, 11 retired)
//   SB_AW      stored register-address width; REG_AW is zero-extended to it
//   sb_entry_t {valid, rd, regwrite, memread} of one pipeline stage
//   sb_match   true when an entry produces the value of source register r
package rv_pp_pkg;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_RET   = 2'b11;
    localparam int SB_AW = 8;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic             regwrite;
        logic             memread;
    } sb_entry_t;

    // x0 is hard-wired zero, so it never matches.
    function automatic logic sb_match(input sb_entry_t e, input logic [SB_AW-1:0] r);
        return e.valid && e.regwrite && e.rd == r && r != '0;
    endfunction
endpackage

// File: rtl/rv_hazard_ctrl_if.sv
// rv_hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
// master: pipeline side, drives ID fields, br_taken_mem, mem_ready; reads controls.
// slave : hazard controller, reads ID/branch/memory status; drives stall, flush,
//         freeze, forwarding selects and perf counters.
interface rv_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              br_taken_mem;
    logic              mem_ready;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic [2:0]        flush;
    logic              freeze;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, br_taken_mem, mem_ready,
        input  pc_write, ifid_write, idex_bubble, flush, freeze, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, br_taken_mem, mem_ready,
        output pc_write, ifid_write, idex_bubble, flush, freeze, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/rv_hazard_ctrl_fwd_select.sv
// rv_fwd_select: priority matcher choosing the EX operand source for one register.
// Ports: s1_i/s2_i/s3_i MEM, WB and retired scoreboard entries; src_i source
//        register of the EX instruction; fwd_o operand select (youngest match wins).
module rv_fwd_select
    import rv_pp_pkg::*;
(
    input  sb_entry_t        s1_i,
    input  sb_entry_t        s2_i,
    input  sb_entry_t        s3_i,
    input  logic [SB_AW-1:0] src_i,
    output logic [1:0]       fwd_o
);
    logic unused_memread;
    assign unused_memread = ^{s1_i.memread, s2_i.memread, s3_i.memread};

    always_comb
        fwd_o = sb_match(s1_i, src_i) ? FWD_EXMEM :
                sb_match(s2_i, src_i) ? FWD_MEMWB :
                sb_match(s3_i, src_i) ? FWD_RET : FWD_RF;
endmodule

// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: combined hazard detection, flush/freeze control and forwarding.
// Ports: clk; rst_n synchronous active-low reset; bus (slave) carries the ID
//        instruction fields, br_taken_mem, mem_ready and all control outputs.
// Scoreboard S0..S2 mirrors ID/EX, EX/MEM, MEM/WB; S3 (retired) exists only
// when the register file does not write through (RF_BYPASS=0).
module rv_hazard_ctrl
    import rv_pp_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int FLUSH_DEPTH = 3,
    parameter int RF_BYPASS   = 1,
    parameter int CNT_W       = 32
) (
    input logic             clk,
    input logic             rst_n,
    rv_hazard_ctrl_if.slave bus
);
    localparam logic [2:0] FLUSH_MASK = 3'((1 << FLUSH_DEPTH) - 1);

    sb_entry_t        s0_q, s1_q, s2_q, s3_q, s0_d, id_e;
    logic [SB_AW-1:0] rs1_q, rs2_q, rs1_d, rs2_d, id_rs1, id_rs2;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic [2:0]       flush_d;
    logic [1:0]       fwd_a, fwd_b;
    logic             frz, br, lu, stall, kill;

    always_comb begin
        id_rs1  = SB_AW'(bus.id_rs1[REG_AW-1:0]);
        id_rs2  = SB_AW'(bus.id_rs2[REG_AW-1:0]);
        id_e    = '{valid: bus.id_valid, rd: SB_AW'(bus.id_rd[REG_AW-1:0]),
                    regwrite: bus.id_regwrite, memread: bus.id_memread};
        frz     = !bus.mem_ready;
        // A branch is only acted on once memory can complete.
        br      = bus.br_taken_mem && bus.mem_ready;
        lu      = bus.id_valid && s0_q.memread && (sb_match(s0_q, id_rs1) || sb_match(s0_q, id_rs2));
        // While frozen the stall stays pending and takes effect after the freeze.
        stall   = !frz && !br && lu;
        flush_d = frz ? 3'b000 : br ? FLUSH_MASK : 3'b000;
        kill    = stall || flush_d[1];
        s0_d    = kill ? '0 : id_e;
        rs1_d   = kill ? '0 : id_rs1;
        rs2_d   = kill ? '0 : id_rs2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!frz) begin
                s0_q  <= s0_d;
                s1_q  <= flush_d[2] ? '0 : s0_q;
                s2_q  <= s1_q;
                rs1_q <= rs1_d;
                rs2_q <= rs2_d;
            end
            if (stall || frz)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (br)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    if (RF_BYPASS == 0) begin : g_ret
        always_ff @(posedge clk) begin
            if (!rst_n)
                s3_q <= '0;
            else if (!frz)
                s3_q <= s2_q;
        end
    end else begin : g_no_ret
        assign s3_q = '0;
    end

    rv_fwd_select u_fwd_a (.s1_i(s1_q), .s2_i(s2_q), .s3_i(s3_q), .src_i(rs1_q), .fwd_o(fwd_a));
    rv_fwd_select u_fwd_b (.s1_i(s1_q), .s2_i(s2_q), .s3_i(s3_q), .src_i(rs2_q), .fwd_o(fwd_b));

    // Outputs show reset values in the very cycle rst_n is sampled low.
    assign bus.freeze      = rst_n && frz;
    assign bus.pc_write    = !rst_n || (!frz && !stall);
    assign bus.ifid_write  = !rst_n || (!frz && !stall);
    assign bus.idex_bubble = rst_n && stall;
    assign bus.flush       = rst_n ? flush_d : 3'b000;
    assign bus.fwd_a       = rst_n ? fwd_a : FWD_RF;
    assign bus.fwd_b       = rst_n ? fwd_b : FWD_RF;
    assign bus.stall_cnt   = rst_n ? stall_cnt_q : '0;
    assign bus.flush_cnt   = rst_n ? flush_cnt_q : '0;
endmodule
